// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - shared opcode, state and mux-select encodings for the RV32I multi-cycle control
package multi_cycle_ctrl_pkg;

    // Major opcodes retired by this core; anything else traps
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;

    // 4-bit state encodings, also exported on the State debug port
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WB = 4'd5,
        S_MEM_WR = 4'd6,
        S_EXEC_R = 4'd7,
        S_EXEC_I = 4'd8,
        S_ALU_WB = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    // ALU B-input select; 10 also picks the immediate generator output
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // ALU operation class handed to the ALU control
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // States that own a memory transaction and wait on MemReady
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_mem_watchdog.sv
// rtl/multi_cycle_ctrl_mem_watchdog.sv - counts consecutive MemReady-low cycles and flags a stuck access
module mem_watchdog #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    // TIMEOUT of 0 turns the watchdog off entirely
    localparam bit            ENABLE = (TIMEOUT != 0);
    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Wait-cycle counter: clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TO_W'(1);
        end
    end

    // Fires on the wait cycle that would bring the count up to TIMEOUT;
    // a ready cycle never increments, so MemReady beats the timeout
    always_comb begin
        expired = ENABLE && inc && !clear && (count == LIMIT);
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - main control FSM of the multi-cycle RV32I datapath
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             Halt,
    output logic [CNT_W-1:0] InstRetired,
    output logic [3:0]       State
);

    state_t state;
    state_t next_state;
    logic   in_mem;
    logic   wd_clear;
    logic   wd_inc;
    logic   wd_expired;
    logic   retire;

    // Watchdog only runs while a memory state is stalled on MemReady
    always_comb begin
        in_mem   = is_mem_state(state);
        wd_clear = !in_mem || MemReady;
        wd_inc   = in_mem && !MemReady;
    end

    mem_watchdog #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_mem_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .inc     (wd_inc),
        .expired (wd_expired)
    );

    // State register; async reset drops every strobe at once since outputs decode from state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH: begin
                if (wd_expired)    next_state = S_TRAP;
                else if (MemReady) next_state = S_DECODE;
            end
            S_DECODE: begin
                case (Opcode)
                    OP_LOAD, OP_STORE: next_state = S_ADDR;
                    OP_IMM:            next_state = S_EXEC_I;
                    OP_R:              next_state = S_EXEC_R;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_ADDR: begin
                case (Opcode)
                    OP_LOAD:  next_state = S_MEM_RD;
                    OP_STORE: next_state = S_MEM_WR;
                    default:  next_state = S_TRAP;
                endcase
            end
            S_MEM_RD: begin
                if (wd_expired)    next_state = S_TRAP;
                else if (MemReady) next_state = S_MEM_WB;
            end
            S_MEM_WB: next_state = S_FETCH;
            S_MEM_WR: begin
                if (wd_expired)    next_state = S_TRAP;
                else if (MemReady) next_state = S_FETCH;
            end
            S_EXEC_R: next_state = S_ALU_WB;
            S_EXEC_I: next_state = S_ALU_WB;
            S_ALU_WB: next_state = S_FETCH;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_TRAP;
        endcase
    end

    // Output decode; IRWrite/PCWrite are Mealy on the FETCH completion cycle
    always_comb begin
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = SRCB_RS2;
        ALUOp    = ALUOP_ADD;
        Halt     = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (MemReady) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            S_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_R;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_I;
            end
            S_ALU_WB: RegWrite = 1'b1;
            S_TRAP:   Halt     = 1'b1;
            default:  ;
        endcase
        State = state;
    end

    // An instruction retires when a write-back or store state hands over to FETCH
    always_comb begin
        retire = (next_state == S_FETCH) &&
                 ((state == S_MEM_WB) || (state == S_MEM_WR) || (state == S_ALU_WB));
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstRetired <= '0;
        end else if (retire) begin
            InstRetired <= InstRetired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed table-driven bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    localparam int CW = 3;

    // Expected state codes
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_ADDR   = 4'd3;
    localparam logic [3:0] ST_MEM_RD = 4'd4;
    localparam logic [3:0] ST_MEM_WB = 4'd5;
    localparam logic [3:0] ST_MEM_WR = 4'd6;
    localparam logic [3:0] ST_EXEC_R = 4'd7;
    localparam logic [3:0] ST_EXEC_I = 4'd8;
    localparam logic [3:0] ST_ALU_WB = 4'd9;
    localparam logic [3:0] ST_TRAP   = 4'd10;

    // Control word: PCWrite IRWrite IorD MemRead MemWrite MemtoReg RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] Halt
    localparam logic [12:0] C_NONE  = 13'b0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [12:0] C_FWAIT = 13'b0_0_0_1_0_0_0_0_01_00_0;
    localparam logic [12:0] C_FGO   = 13'b1_1_0_1_0_0_0_0_01_00_0;
    localparam logic [12:0] C_ADDR  = 13'b0_0_0_0_0_0_0_1_10_00_0;
    localparam logic [12:0] C_MEMRD = 13'b0_0_1_1_0_0_0_0_00_00_0;
    localparam logic [12:0] C_MEMWB = 13'b0_0_0_0_0_1_1_0_00_00_0;
    localparam logic [12:0] C_MEMWR = 13'b0_0_1_0_1_0_0_0_00_00_0;
    localparam logic [12:0] C_EXECR = 13'b0_0_0_0_0_0_0_1_00_10_0;
    localparam logic [12:0] C_EXECI = 13'b0_0_0_0_0_0_0_1_10_11_0;
    localparam logic [12:0] C_ALUWB = 13'b0_0_0_0_0_0_1_0_00_00_0;
    localparam logic [12:0] C_TRAP  = 13'b0_0_0_0_0_0_0_0_00_00_1;

    localparam logic [6:0] OPL = 7'h03;
    localparam logic [6:0] OPI = 7'h13;
    localparam logic [6:0] OPS = 7'h23;
    localparam logic [6:0] OPR = 7'h33;
    localparam logic [6:0] OPX = 7'h7F;

    logic          clk;
    logic          rst_n;
    logic [6:0]    opcode;
    logic          mem_ready;
    logic          pc_write, ir_write, iord, mem_read, mem_write, memto_reg, reg_write, alu_src_a;
    logic [1:0]    alu_src_b, alu_op;
    logic          halt;
    logic [CW-1:0] inst_retired;
    logic [3:0]    state;
    logic [12:0]   ctrl;

    assign ctrl = {pc_write, ir_write, iord, mem_read, mem_write, memto_reg, reg_write,
                   alu_src_a, alu_src_b, alu_op, halt};

    multi_cycle_ctrl #(
        .TO_W    (8),
        .TIMEOUT (4),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (opcode),
        .MemReady    (mem_ready),
        .PCWrite     (pc_write),
        .IRWrite     (ir_write),
        .IorD        (iord),
        .MemRead     (mem_read),
        .MemWrite    (mem_write),
        .MemtoReg    (memto_reg),
        .RegWrite    (reg_write),
        .ALUSrcA     (alu_src_a),
        .ALUSrcB     (alu_src_b),
        .ALUOp       (alu_op),
        .Halt        (halt),
        .InstRetired (inst_retired),
        .State       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required end before 200000");
        $fatal(1);
    end

    typedef struct {
        logic [6:0]    op;
        logic          mr;
        logic [3:0]    st;
        logic [12:0]   ctl;
        logic [CW-1:0] ret;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(input logic [6:0] op, input logic mr, input logic [3:0] st,
                                input logic [12:0] ctl, input logic [CW-1:0] ret);
        vec_t v;
        v.op = op; v.mr = mr; v.st = st; v.ctl = ctl; v.ret = ret;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, required %0h", name, idx, act, exp);
        end
    endtask

    // Drive inputs just after a rising edge, sample on the falling edge, move to next edge
    task automatic step(input string name, input int idx, input logic [6:0] op, input logic mr,
                        input logic [3:0] st, input logic [12:0] ctl, input logic [CW-1:0] ret);
        opcode    = op;
        mem_ready = mr;
        @(negedge clk);
        chk({name, "_state"}, idx, 32'(state), 32'(st));
        chk({name, "_ctrl"},  idx, 32'(ctrl),  32'(ctl));
        chk({name, "_ret"},   idx, 32'(inst_retired), 32'(ret));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_state", 0, 32'(state), 32'(ST_IDLE));
        chk("rst_ctrl",  0, 32'(ctrl),  32'(C_NONE));
        chk("rst_ret",   0, 32'(inst_retired), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ctrl", 0, 32'(ctrl), 32'(C_NONE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        opcode    = 7'h00;
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        // addi: IDLE, FETCH, DECODE, EXEC_I, ALU_WB
        add(OPI, 1, ST_IDLE,   C_NONE,  0);
        add(OPI, 1, ST_FETCH,  C_FGO,   0);
        add(OPI, 1, ST_DECODE, C_NONE,  0);
        add(OPI, 1, ST_EXEC_I, C_EXECI, 0);
        add(OPI, 1, ST_ALU_WB, C_ALUWB, 0);
        // load with 3 wait cycles in MEM_RD: 8 cycles total
        add(OPL, 1, ST_FETCH,  C_FGO,   1);
        add(OPL, 1, ST_DECODE, C_NONE,  1);
        add(OPL, 1, ST_ADDR,   C_ADDR,  1);
        add(OPL, 0, ST_MEM_RD, C_MEMRD, 1);
        add(OPL, 0, ST_MEM_RD, C_MEMRD, 1);
        add(OPL, 0, ST_MEM_RD, C_MEMRD, 1);
        add(OPL, 1, ST_MEM_RD, C_MEMRD, 1);
        add(OPL, 1, ST_MEM_WB, C_MEMWB, 1);
        // store then R-type, zero wait
        add(OPS, 1, ST_FETCH,  C_FGO,   2);
        add(OPS, 1, ST_DECODE, C_NONE,  2);
        add(OPS, 1, ST_ADDR,   C_ADDR,  2);
        add(OPS, 1, ST_MEM_WR, C_MEMWR, 2);
        add(OPR, 1, ST_FETCH,  C_FGO,   3);
        add(OPR, 1, ST_DECODE, C_NONE,  3);
        add(OPR, 1, ST_EXEC_R, C_EXECR, 3);
        add(OPR, 1, ST_ALU_WB, C_ALUWB, 3);
        // FETCH: 3 wait cycles then ready on the cycle the count would hit TIMEOUT
        add(OPI, 0, ST_FETCH,  C_FWAIT, 4);
        add(OPI, 0, ST_FETCH,  C_FWAIT, 4);
        add(OPI, 0, ST_FETCH,  C_FWAIT, 4);
        add(OPI, 1, ST_FETCH,  C_FGO,   4);
        add(OPI, 1, ST_DECODE, C_NONE,  4);
        add(OPI, 1, ST_EXEC_I, C_EXECI, 4);
        add(OPI, 1, ST_ALU_WB, C_ALUWB, 4);
        // FETCH: 4 wait cycles -> TRAP
        add(OPI, 0, ST_FETCH,  C_FWAIT, 5);
        add(OPI, 0, ST_FETCH,  C_FWAIT, 5);
        add(OPI, 0, ST_FETCH,  C_FWAIT, 5);
        add(OPI, 0, ST_FETCH,  C_FWAIT, 5);
        add(OPI, 0, ST_TRAP,   C_TRAP,  5);
        add(OPI, 1, ST_TRAP,   C_TRAP,  5);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            step("vec", i, vecs[i].op, vecs[i].mr, vecs[i].st, vecs[i].ctl, vecs[i].ret);
        end

        // Illegal opcode: TRAP held 50 cycles, then async reset clears Halt
        do_reset();
        step("ill", 0, OPX, 1, ST_IDLE,   C_NONE, 0);
        step("ill", 1, OPX, 1, ST_FETCH,  C_FGO,  0);
        step("ill", 2, OPX, 1, ST_DECODE, C_NONE, 0);
        for (int i = 0; i < 50; i++) begin
            step("ill_trap", i, OPX, logic'(i % 2), ST_TRAP, C_TRAP, 0);
        end
        rst_n = 1'b0;
        #1;
        chk("ill_rst_halt",  0, 32'(halt),  0);
        chk("ill_rst_state", 0, 32'(state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("ill_rel", 0, OPI, 1, ST_IDLE,  C_NONE, 0);
        step("ill_rel", 1, OPI, 1, ST_FETCH, C_FGO,  0);

        // Retired counter wraps after 2**CW instructions
        do_reset();
        step("wrap_idle", 0, OPI, 1, ST_IDLE, C_NONE, 0);
        for (int k = 0; k < 8; k++) begin
            step("wrap_f", k, OPI, 1, ST_FETCH,  C_FGO,   CW'(k));
            step("wrap_d", k, OPI, 1, ST_DECODE, C_NONE,  CW'(k));
            step("wrap_e", k, OPI, 1, ST_EXEC_I, C_EXECI, CW'(k));
            step("wrap_w", k, OPI, 1, ST_ALU_WB, C_ALUWB, CW'(k));
        end
        step("wrap_end", 0, OPI, 0, ST_FETCH, C_FWAIT, 0);

        // Async reset mid-cycle in MEM_WR drops MemWrite before the next edge
        do_reset();
        step("arst", 0, OPS, 1, ST_IDLE,   C_NONE, 0);
        step("arst", 1, OPS, 1, ST_FETCH,  C_FGO,  0);
        step("arst", 2, OPS, 1, ST_DECODE, C_NONE, 0);
        step("arst", 3, OPS, 1, ST_ADDR,   C_ADDR, 0);
        opcode    = OPS;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("arst_memwr_ctrl", 0, 32'(ctrl), 32'(C_MEMWR));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_memwrite", 0, 32'(mem_write), 0);
        chk("arst_ctrl",     0, 32'(ctrl),      32'(C_NONE));
        chk("arst_state",    0, 32'(state),     32'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("arst_rel", 0, OPI, 1, ST_IDLE,  C_NONE, 0);
        step("arst_rel", 1, OPI, 1, ST_FETCH, C_FGO,  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
